// File: rtl/line_print_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : line_print_sequencer_if                                    |
// | Purpose   : Bundles the control, pointer-table, char-memory and byte   |
// |             stream signals of the line print sequencer.                |
// |   master  : sequencer side (drives busy/done/ptr_addr/mem_*/tx_data/   |
// |             tx_valid, receives start/line_sel/ptr_data/mem_dout/       |
// |             tx_ready).                                                 |
// |   slave   : environment side (mirror directions).                      |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
interface line_print_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int LINE_W = 8
);
  logic                  start;
  logic [LINE_W-1:0]     line_sel;
  logic                  busy;
  logic                  done;
  logic [LINE_W-1:0]     ptr_addr;
  logic [2*ADDR_W-1:0]   ptr_data;
  logic                  mem_rd;
  logic [ADDR_W-1:0]     mem_addr;
  logic [15:0]           mem_dout;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    input  start, line_sel, ptr_data, mem_dout, tx_ready,
    output busy, done, ptr_addr, mem_rd, mem_addr, tx_data, tx_valid
  );

  modport slave (
    output start, line_sel, ptr_data, mem_dout, tx_ready,
    input  busy, done, ptr_addr, mem_rd, mem_addr, tx_data, tx_valid
  );
endinterface
`default_nettype wire

// File: rtl/line_print_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : line_print_sequencer                                       |
// | Purpose   : Prints one transform line as a byte stream: looks up the   |
// |             line's {len,start} pointer entry, walks the char memory    |
// |             once for the lhs bytes and once for the rhs bytes, and     |
// |             emits lhs, SEP_CHAR, rhs, CR, LF on a valid/ready port.    |
// | Ports     : clk   - clock, rising edge                                 |
// |             rst_n - synchronous reset, active low                      |
// |             bus   - line_print_sequencer_if.master (start/line_sel,    |
// |                     busy/done, pointer table, char memory, tx stream)  |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module line_print_sequencer #(
  parameter int         ADDR_W   = 10,
  parameter int         LINE_W   = 8,
  parameter logic [7:0] SEP_CHAR = 8'h3D
) (
  input  logic                   clk,
  input  logic                   rst_n,
  line_print_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_PTR  = 4'd1,
    S_PTRW = 4'd2,
    S_RD   = 4'd3,
    S_CAP  = 4'd4,
    S_EMIT = 4'd5,
    S_SEP  = 4'd6,
    S_CR   = 4'd7,
    S_LF   = 4'd8,
    S_FIN  = 4'd9
  } state_t;

  state_t              state_q,    state_d;
  logic [LINE_W-1:0]   ptr_addr_q, ptr_addr_d;
  logic [ADDR_W-1:0]   base_q,     base_d;
  logic [ADDR_W-1:0]   len_q,      len_d;
  logic [ADDR_W:0]     idx_q,      idx_d;    // one bit wider so idx+1 can reach 1024
  logic                pass_q,     pass_d;   // 0 = lhs (high byte), 1 = rhs (low byte)
  logic [7:0]          byte_q,     byte_d;

  logic                hs;
  logic [ADDR_W:0]     idx_inc;
  logic [ADDR_W-1:0]   len_field;

  assign hs        = bus.tx_valid & bus.tx_ready;
  assign idx_inc   = idx_q + {{ADDR_W{1'b0}}, 1'b1};
  assign len_field = bus.ptr_data[2*ADDR_W-1:ADDR_W];

  // Outputs are decoded from the current state so that mem_rd and tx_valid
  // are asserted exactly in their owning states.
  always_comb begin
    bus.busy     = (state_q != S_IDLE) && (state_q != S_FIN);
    bus.done     = (state_q == S_FIN);
    bus.ptr_addr = ptr_addr_q;
    bus.mem_rd   = (state_q == S_RD);
    // Address arithmetic wraps naturally at ADDR_W bits.
    bus.mem_addr = (state_q == S_RD) ? (base_q + idx_q[ADDR_W-1:0]) : '0;
    bus.tx_valid = (state_q == S_EMIT) || (state_q == S_SEP) ||
                   (state_q == S_CR)   || (state_q == S_LF);
    unique case (state_q)
      S_SEP:   bus.tx_data = SEP_CHAR;
      S_CR:    bus.tx_data = 8'h0D;
      S_LF:    bus.tx_data = 8'h0A;
      default: bus.tx_data = byte_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ptr_addr_d = ptr_addr_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    byte_d     = byte_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ptr_addr_d = bus.line_sel;
          state_d    = S_PTR;
        end
      end
      S_PTR: state_d = S_PTRW;
      S_PTRW: begin
        base_d  = bus.ptr_data[ADDR_W-1:0];
        len_d   = len_field;
        idx_d   = '0;
        pass_d  = 1'b0;
        state_d = (len_field == '0) ? S_SEP : S_RD;
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        byte_d  = pass_q ? bus.mem_dout[7:0] : bus.mem_dout[15:8];
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (hs) begin
          idx_d = idx_inc;
          if (idx_inc < {1'b0, len_q}) begin
            state_d = S_RD;
          end else if (!pass_q) begin
            state_d = S_SEP;
          end else begin
            state_d = S_CR;
          end
        end
      end
      S_SEP: begin
        if (hs) begin
          idx_d   = '0;
          pass_d  = 1'b1;
          state_d = (len_q == '0) ? S_CR : S_RD;
        end
      end
      S_CR:    if (hs) state_d = S_LF;
      S_LF:    if (hs) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_addr_q <= '0;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      pass_q     <= 1'b0;
      byte_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_addr_q <= ptr_addr_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      byte_q     <= byte_d;
    end
  end

endmodule
`default_nettype wire
